// File: rtl/arm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_ctrl_pkg
// Brief    : Shared encodings for the micro ARM multicycle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package arm_ctrl_pkg;

  localparam logic [1:0] c_OP_DP  = 2'b00;
  localparam logic [1:0] c_OP_MEM = 2'b01;
  localparam logic [1:0] c_OP_B   = 2'b10;
  localparam logic [1:0] c_OP_ILL = 2'b11;

  localparam logic [3:0] c_CMD_AND = 4'b0000;
  localparam logic [3:0] c_CMD_SUB = 4'b0010;
  localparam logic [3:0] c_CMD_ADD = 4'b0100;
  localparam logic [3:0] c_CMD_ORR = 4'b1100;

  localparam logic [3:0] c_COND_EQ = 4'b0000;
  localparam logic [3:0] c_COND_NE = 4'b0001;
  localparam logic [3:0] c_COND_CS = 4'b0010;
  localparam logic [3:0] c_COND_CC = 4'b0011;
  localparam logic [3:0] c_COND_MI = 4'b0100;
  localparam logic [3:0] c_COND_PL = 4'b0101;
  localparam logic [3:0] c_COND_VS = 4'b0110;
  localparam logic [3:0] c_COND_VC = 4'b0111;
  localparam logic [3:0] c_COND_HI = 4'b1000;
  localparam logic [3:0] c_COND_LS = 4'b1001;
  localparam logic [3:0] c_COND_GE = 4'b1010;
  localparam logic [3:0] c_COND_LT = 4'b1011;
  localparam logic [3:0] c_COND_GT = 4'b1100;
  localparam logic [3:0] c_COND_LE = 4'b1101;
  localparam logic [3:0] c_COND_AL = 4'b1110;
  localparam logic [3:0] c_COND_NV = 4'b1111;

  localparam logic [1:0] c_ALU_ADD = 2'b00;
  localparam logic [1:0] c_ALU_SUB = 2'b01;
  localparam logic [1:0] c_ALU_AND = 2'b10;
  localparam logic [1:0] c_ALU_ORR = 2'b11;

  localparam logic [1:0] c_RES_ALUOUT = 2'b00;
  localparam logic [1:0] c_RES_DATA   = 2'b01;
  localparam logic [1:0] c_RES_ALU    = 2'b10;

  localparam logic [1:0] c_SRCB_REG  = 2'b00;
  localparam logic [1:0] c_SRCB_IMM  = 2'b01;
  localparam logic [1:0] c_SRCB_FOUR = 2'b10;

  localparam int unsigned c_FLAG_N = 3;
  localparam int unsigned c_FLAG_Z = 2;
  localparam int unsigned c_FLAG_C = 1;
  localparam int unsigned c_FLAG_V = 0;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    UPD_NONE = 2'd0,
    UPD_NZ   = 2'd1,
    UPD_NZCV = 2'd2
  } flag_upd_t;

  typedef struct packed {
    logic [1:0] alu_ctrl;
    flag_upd_t  upd;
  } cmd_dec_t;

  // Unknown commands still execute as ADD but never touch the flags.
  function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
    cmd_dec_t d;
    d.alu_ctrl = c_ALU_ADD;
    d.upd      = UPD_NONE;
    case (cmd)
      c_CMD_ADD: begin d.alu_ctrl = c_ALU_ADD; d.upd = UPD_NZCV; end
      c_CMD_SUB: begin d.alu_ctrl = c_ALU_SUB; d.upd = UPD_NZCV; end
      c_CMD_AND: begin d.alu_ctrl = c_ALU_AND; d.upd = UPD_NZ;   end
      c_CMD_ORR: begin d.alu_ctrl = c_ALU_ORR; d.upd = UPD_NZ;   end
      default:   begin d.alu_ctrl = c_ALU_ADD; d.upd = UPD_NONE; end
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_cond_check.sv
`default_nettype none
// ============================================================================
// Module   : cond_check
// Brief    : ARM condition-code evaluation against registered NZCV.
// Revision : 1.0 - initial release
// ============================================================================
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       ce
);

  logic w_n, w_z, w_c, w_v, w_ge;

  assign w_n  = flags[c_FLAG_N];
  assign w_z  = flags[c_FLAG_Z];
  assign w_c  = flags[c_FLAG_C];
  assign w_v  = flags[c_FLAG_V];
  assign w_ge = (w_n == w_v);

  always_comb begin
    ce = 1'b0;
    case (cond)
      c_COND_EQ: ce = w_z;
      c_COND_NE: ce = ~w_z;
      c_COND_CS: ce = w_c;
      c_COND_CC: ce = ~w_c;
      c_COND_MI: ce = w_n;
      c_COND_PL: ce = ~w_n;
      c_COND_VS: ce = w_v;
      c_COND_VC: ce = ~w_v;
      c_COND_HI: ce = w_c & ~w_z;
      c_COND_LS: ce = ~w_c | w_z;
      c_COND_GE: ce = w_ge;
      c_COND_LT: ce = ~w_ge;
      c_COND_GT: ce = ~w_z & w_ge;
      c_COND_LE: ce = w_z | ~w_ge;
      c_COND_AL: ce = 1'b1;
      default:   ce = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore FSM sequencer with NZCV flags register and condition gating.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       pc_we,
  output logic       adr_src,
  output logic       ir_we,
  output logic       mem_we,
  output logic       reg_we,
  output logic [1:0] result_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [1:0] alu_ctrl,
  output logic [3:0] flags,
  output logic       instr_done
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_flags;
  logic       r_ce;
  logic       w_ce_now;
  logic       w_flag_we;
  logic [3:0] w_flags_next;
  logic       w_imm;
  logic       w_s_or_l;
  logic       w_pc_dest;
  cmd_dec_t   w_cmd;

  cond_check u_cond_check (
    .cond  (cond),
    .flags (r_flags),
    .ce    (w_ce_now)
  );

  assign w_imm     = funct[5];
  assign w_s_or_l  = funct[0];
  assign w_pc_dest = (rd == 4'd15);
  assign w_cmd     = decode_cmd(funct[4:1]);

  assign flags   = r_flags;
  assign imm_src = op;
  assign reg_src = {(op == c_OP_MEM) && !w_s_or_l, (op == c_OP_B)};

  // ce is frozen at the end of DECODE so the instruction's own flag
  // update in EXEC cannot change its writeback gating in ALUWB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_flags <= 4'b0000;
      r_ce    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_ce <= w_ce_now;
      if (w_flag_we) r_flags <= w_flags_next;
    end
  end

  always_comb begin
    w_flags_next = r_flags;
    if (w_cmd.upd == UPD_NZCV) begin
      w_flags_next = alu_flags;
    end else if (w_cmd.upd == UPD_NZ) begin
      w_flags_next[c_FLAG_N] = alu_flags[c_FLAG_N];
      w_flags_next[c_FLAG_Z] = alu_flags[c_FLAG_Z];
    end
  end

  always_comb begin
    w_next     = r_state;
    pc_we      = 1'b0;
    adr_src    = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    result_src = c_RES_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = c_SRCB_REG;
    alu_ctrl   = c_ALU_ADD;
    instr_done = 1'b0;
    w_flag_we  = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_next     = S_DECODE;
        ir_we      = 1'b1;
        pc_we      = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = c_SRCB_FOUR;
        result_src = c_RES_ALU;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = c_SRCB_FOUR;
        result_src = c_RES_ALU;
        case (op)
          c_OP_MEM: w_next = S_MEMADR;
          c_OP_DP:  w_next = w_imm ? S_EXECI : S_EXECR;
          c_OP_B:   w_next = S_BRANCH;
          default: begin
            w_next     = S_FETCH;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_next    = w_s_or_l ? S_MEMRD : S_MEMWR;
        alu_src_b = c_SRCB_IMM;
      end
      S_MEMRD: begin
        w_next  = S_MEMWB;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_next     = S_FETCH;
        result_src = c_RES_DATA;
        reg_we     = r_ce;
        pc_we      = r_ce && w_pc_dest;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        w_next     = S_FETCH;
        adr_src    = 1'b1;
        mem_we     = r_ce;
        instr_done = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        w_next    = S_ALUWB;
        alu_src_b = (r_state == S_EXECI) ? c_SRCB_IMM : c_SRCB_REG;
        alu_ctrl  = w_cmd.alu_ctrl;
        w_flag_we = w_s_or_l && r_ce && (w_cmd.upd != UPD_NONE);
      end
      S_ALUWB: begin
        w_next     = S_FETCH;
        reg_we     = r_ce;
        pc_we      = r_ce && w_pc_dest;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_next     = S_FETCH;
        alu_src_b  = c_SRCB_IMM;
        result_src = c_RES_ALU;
        pc_we      = r_ce;
        instr_done = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase

    // No architectural side effect may escape while reset is held.
    if (rst) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      instr_done = 1'b0;
      w_flag_we  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Cycle-by-cycle scoreboard bench for the multicycle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       pc_we, adr_src, ir_we, mem_we, reg_we, alu_src_a, instr_done;
  logic [1:0] result_src, alu_src_b, imm_src, reg_src, alu_ctrl;
  logic [3:0] flags;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .pc_we(pc_we), .adr_src(adr_src), .ir_we(ir_we),
    .mem_we(mem_we), .reg_we(reg_we), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .reg_src(reg_src), .alu_ctrl(alu_ctrl), .flags(flags),
    .instr_done(instr_done)
  );

  // pc adr ir mem reg | result_src | srca | srcb | alu_ctrl | done | flags | imm | rsrc
  typedef struct packed {
    logic       pc_we;
    logic       adr_src;
    logic       ir_we;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl;
    logic       instr_done;
    logic [3:0] flags;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
  } ctl_t;

  typedef struct {
    ctl_t  c;
    string tag;
  } exp_t;

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp_ce;
  } vec_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_flags = 4'b0000;
  vec_t       vecs[64];

  function automatic ctl_t mk(input logic pc, input logic adr, input logic ir,
                              input logic mem, input logic rg, input logic [1:0] rs,
                              input logic a, input logic [1:0] b, input logic [1:0] ac,
                              input logic done, input logic [3:0] fl);
    ctl_t c;
    c.pc_we = pc; c.adr_src = adr; c.ir_we = ir; c.mem_we = mem; c.reg_we = rg;
    c.result_src = rs; c.alu_src_a = a; c.alu_src_b = b; c.alu_ctrl = ac;
    c.instr_done = done; c.flags = fl; c.imm_src = 2'b00; c.reg_src = 2'b00;
    return c;
  endfunction

  function automatic logic [1:0] exp_alu(input logic [3:0] cmd);
    if (cmd == 4'b0100) return 2'b00;
    if (cmd == 4'b0010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  task automatic push(input ctl_t c, input logic [1:0] is, input logic [1:0] rs2, input string tag);
    exp_t e;
    e.c = c;
    e.c.imm_src = is;
    e.c.reg_src = rs2;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      ctl_t obs;
      e = exp_q.pop_front();
      obs = '{pc_we, adr_src, ir_we, mem_we, reg_we, result_src, alu_src_a,
              alu_src_b, alu_ctrl, instr_done, flags, imm_src, reg_src};
      checks++;
      if (obs !== e.c) begin
        errors++;
        $display("FAIL %s: got %b required %b (pc adr ir mem reg rs a b ctl done flags imm rsrc)",
                 e.tag, obs, e.c);
      end
    end
  end

  task automatic run_dp(input logic [3:0] c, input logic i, input logic [3:0] cmd,
                        input logic s, input logic [3:0] d, input logic [3:0] af,
                        input logic ce, input string nm);
    logic [3:0] nf;
    cond = c; op = 2'b00; funct = {i, cmd, s}; rd = d; alu_flags = af;
    nf = m_flags;
    if (s && ce && (cmd == 4'b0100 || cmd == 4'b0010)) nf = af;
    else if (s && ce && (cmd == 4'b0000 || cmd == 4'b1100)) nf = {af[3:2], m_flags[1:0]};
    push(mk(1,0,1,0,0,2'b10,1,2'b10,2'b00,0,m_flags), 2'b00, 2'b00, {nm, "/fetch"});
    push(mk(0,0,0,0,0,2'b10,1,2'b10,2'b00,0,m_flags), 2'b00, 2'b00, {nm, "/decode"});
    push(mk(0,0,0,0,0,2'b00,0,i ? 2'b01 : 2'b00,exp_alu(cmd),0,m_flags), 2'b00, 2'b00, {nm, "/exec"});
    push(mk(ce && d == 4'd15,0,0,0,ce,2'b00,0,2'b00,2'b00,1,nf), 2'b00, 2'b00, {nm, "/aluwb"});
    m_flags = nf;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_mem(input logic [3:0] c, input logic l, input logic [3:0] d,
                         input logic ce, input string nm);
    logic [1:0] rs2;
    cond = c; op = 2'b01; funct = {5'b10000, l}; rd = d; alu_flags = 4'b0000;
    rs2 = {~l, 1'b0};
    push(mk(1,0,1,0,0,2'b10,1,2'b10,2'b00,0,m_flags), 2'b01, rs2, {nm, "/fetch"});
    push(mk(0,0,0,0,0,2'b10,1,2'b10,2'b00,0,m_flags), 2'b01, rs2, {nm, "/decode"});
    push(mk(0,0,0,0,0,2'b00,0,2'b01,2'b00,0,m_flags), 2'b01, rs2, {nm, "/memadr"});
    if (l) begin
      push(mk(0,1,0,0,0,2'b00,0,2'b00,2'b00,0,m_flags), 2'b01, rs2, {nm, "/memrd"});
      push(mk(ce && d == 4'd15,0,0,0,ce,2'b01,0,2'b00,2'b00,1,m_flags), 2'b01, rs2, {nm, "/memwb"});
      repeat (5) @(posedge clk);
    end else begin
      push(mk(0,1,0,ce,0,2'b00,0,2'b00,2'b00,1,m_flags), 2'b01, rs2, {nm, "/memwr"});
      repeat (4) @(posedge clk);
    end
    #1;
  endtask

  task automatic run_b(input logic [3:0] c, input logic ce, input string nm);
    cond = c; op = 2'b10; funct = 6'b100000; rd = 4'd0; alu_flags = 4'b0000;
    push(mk(1,0,1,0,0,2'b10,1,2'b10,2'b00,0,m_flags), 2'b10, 2'b01, {nm, "/fetch"});
    push(mk(0,0,0,0,0,2'b10,1,2'b10,2'b00,0,m_flags), 2'b10, 2'b01, {nm, "/decode"});
    push(mk(ce,0,0,0,0,2'b10,0,2'b01,2'b00,1,m_flags), 2'b10, 2'b01, {nm, "/branch"});
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_illegal(input string nm);
    cond = 4'hE; op = 2'b11; funct = 6'b101001; rd = 4'd15; alu_flags = 4'b1111;
    push(mk(1,0,1,0,0,2'b10,1,2'b10,2'b00,0,m_flags), 2'b11, 2'b00, {nm, "/fetch"});
    push(mk(0,0,0,0,0,2'b10,1,2'b10,2'b00,1,m_flags), 2'b11, 2'b00, {nm, "/decode"});
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  fl_sets[4];
    logic [15:0] masks[4];
    logic [15:0] mk_mask;
    fl_sets = '{4'b0000, 4'b1111, 4'b1001, 4'b0110};
    // Bit n of each mask is the ARM pass/fail result for cond=n.
    masks   = '{16'h56AA, 16'h6655, 16'h565A, 16'h66A5};
    for (int f = 0; f < 4; f++) begin
      mk_mask = masks[f];
      for (int c = 0; c < 16; c++) begin
        vecs[f*16 + c].flags  = fl_sets[f];
        vecs[f*16 + c].cond   = 4'(c);
        vecs[f*16 + c].exp_ce = mk_mask[c];
      end
    end

    rst = 1'b1; cond = 4'hE; op = 2'b00; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    push(mk(0,0,0,0,0,2'b10,1,2'b10,2'b00,0,4'b0000), 2'b00, 2'b00, "reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_dp(4'hE, 1'b1, 4'b0100, 1'b1, 4'd3, 4'b0110, 1'b1, "add_imm_s");
    checks++;
    if (flags !== 4'b0110) begin
      errors++;
      $display("FAIL add_flags: got %b required 0110", flags);
    end

    run_mem(4'hE, 1'b1, 4'd15, 1'b1, "ldr_pc");
    run_dp(4'hE, 1'b1, 4'b0100, 1'b1, 4'd1, 4'b0011, 1'b1, "set_0011");
    run_mem(4'h0, 1'b0, 4'd2, 1'b0, "str_eq_fail");
    run_dp(4'hE, 1'b0, 4'b0000, 1'b1, 4'd4, 4'b1000, 1'b1, "and_s_nz");
    checks++;
    if (flags !== 4'b1011) begin
      errors++;
      $display("FAIL and_keeps_cv: got %b required 1011", flags);
    end
    run_dp(4'h0, 1'b0, 4'b0010, 1'b1, 4'd5, 4'b0100, 1'b0, "sub_eq_fail");
    run_dp(4'h1, 1'b1, 4'b0100, 1'b1, 4'd6, 4'b0100, 1'b1, "ne_sets_z");
    run_dp(4'h0, 1'b0, 4'b0010, 1'b1, 4'd7, 4'b0000, 1'b1, "eq_clears_z");
    run_dp(4'hE, 1'b0, 4'b1111, 1'b1, 4'd8, 4'b1111, 1'b1, "other_cmd");
    run_dp(4'hE, 1'b1, 4'b1100, 1'b0, 4'd15, 4'b1111, 1'b1, "orr_to_pc");
    run_b(4'hE, 1'b1, "b_al");
    run_b(4'hF, 1'b0, "b_nv");
    run_illegal("illegal_op");

    for (int k = 0; k < 64; k++) begin
      if (k % 16 == 0)
        run_dp(4'hE, 1'b1, 4'b0100, 1'b1, 4'd1, vecs[k].flags, 1'b1, "set_flags");
      run_dp(vecs[k].cond, 1'b0, 4'b1100, 1'b0, 4'd2, 4'b0000, vecs[k].exp_ce,
             $sformatf("cond%0h_fl%b", vecs[k].cond, vecs[k].flags));
    end

    // LDR abandoned by reset while in MEMRD.
    cond = 4'hE; op = 2'b01; funct = 6'b100001; rd = 4'd9; alu_flags = 4'd0;
    push(mk(1,0,1,0,0,2'b10,1,2'b10,2'b00,0,m_flags), 2'b01, 2'b00, "rst_ldr/fetch");
    push(mk(0,0,0,0,0,2'b10,1,2'b10,2'b00,0,m_flags), 2'b01, 2'b00, "rst_ldr/decode");
    push(mk(0,0,0,0,0,2'b00,0,2'b01,2'b00,0,m_flags), 2'b01, 2'b00, "rst_ldr/memadr");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    push(mk(0,1,0,0,0,2'b00,0,2'b00,2'b00,0,m_flags), 2'b01, 2'b00, "rst_ldr/memrd_rst");
    @(posedge clk);
    #1;
    m_flags = 4'b0000;
    push(mk(0,0,0,0,0,2'b10,1,2'b10,2'b00,0,4'b0000), 2'b01, 2'b00, "rst_ldr/fetch_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_b(4'hE, 1'b1, "after_rst_b");
    run_illegal("illegal_end");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d records left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
